// File: rtl/uart_wb_master.sv
// ---------------------------------------------------------------------------
// uart_wb_master
// UART-to-Wishbone bridge. Parses byte-framed commands from a UART receiver
// and issues single 32-bit Wishbone master cycles. The result goes back to
// the UART transmitter: an ack/error byte, followed by the read data for a
// successful read.
//
// Frames (multi-byte fields MSB first):
//   write : 'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0  -> 'K'
//   read  : 'R'(0x52) A3 A2 A1 A0              -> 'K' D3 D2 D1 D0
//   bus timeout                                -> 'E'
//
// Parameters:
//   TIMEOUT_CYCLES : cycles to wait for wbm_ack_i before reporting 'E';
//                    0 disables the timeout
//   FRAME_TIMEOUT  : idle cycles allowed between the bytes of one frame
//                    (used only when UART_WBM_FRAME_TIMEOUT_EN is defined)
//
// Optional feature: define UART_WBM_FRAME_TIMEOUT_EN to abort a partial
// frame after FRAME_TIMEOUT idle cycles. Without it, a partial frame waits
// indefinitely.
//
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   rx_data/rx_valid  : received byte and its one-cycle strobe
//   rx_frame_err      : qualifies rx_valid, byte had a bad stop bit
//   tx_data/tx_start  : byte to send, request level held until tx_clear
//   tx_clear/tx_busy  : transmitter latched tx_data / is shifting
//   wbm_*             : Wishbone master interface
//   busy              : high in any state except IDLE
// ---------------------------------------------------------------------------
module uart_wb_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FRAME_TIMEOUT  = 400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_frame_err,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_clear,
    input  logic        tx_busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    // state     | meaning
    // ----------+----------------------------------------------------------
    // IDLE      | waiting for a 'W' or 'R' command byte
    // GET_ADDR  | shifting in 4 address bytes
    // GET_DATA  | shifting in 4 write-data bytes
    // WB_REQ    | cyc/stb asserted, waiting for ack or bus timeout
    // RESP      | sending 'K'/'E' and, for a good read, 4 data bytes
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_WB_REQ,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    localparam bit          TMR_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TMR_LOAD = TMR_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t      state, state_d;
    logic        we, we_d;
    logic [1:0]  cnt, cnt_d;
    logic [31:0] adr, adr_d;
    logic [31:0] dat, dat_d;
    logic [31:0] rdata, rdata_d;
    logic [2:0]  idx, idx_d;
    logic        err, err_d;
    logic [7:0]  txd, txd_d;
    logic        txs, txs_d;
    logic        cyc, cyc_d;
    logic [31:0] tmr, tmr_d;
    logic [7:0]  resp_byte;
    logic        rx_good;
    logic        rx_bad;

`ifdef UART_WBM_FRAME_TIMEOUT_EN
    localparam logic [31:0] FT_LOAD = 32'(FRAME_TIMEOUT - 1);
    logic [31:0] ftmr, ftmr_d;
`endif

    assign rx_good = rx_valid && !rx_frame_err;
    assign rx_bad  = rx_valid &&  rx_frame_err;

    // idx 0 is the status byte, 1..4 are the read data bytes MSB first
    always_comb begin
        resp_byte = 8'h00;
        case (idx)
            3'd0:    resp_byte = err ? RSP_ERR : RSP_OK;
            3'd1:    resp_byte = rdata[31:24];
            3'd2:    resp_byte = rdata[23:16];
            3'd3:    resp_byte = rdata[15:8];
            3'd4:    resp_byte = rdata[7:0];
            default: resp_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state;
        we_d    = we;
        cnt_d   = cnt;
        adr_d   = adr;
        dat_d   = dat;
        rdata_d = rdata;
        idx_d   = idx;
        err_d   = err;
        txd_d   = txd;
        txs_d   = txs;
        cyc_d   = cyc;
        tmr_d   = tmr;
`ifdef UART_WBM_FRAME_TIMEOUT_EN
        ftmr_d  = ftmr;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_good && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    we_d    = (rx_data == CMD_WRITE);
                    cnt_d   = 2'd0;
                    state_d = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (rx_bad) begin
                    state_d = ST_IDLE;
                end else if (rx_good) begin
                    adr_d = {adr[23:0], rx_data};
                    cnt_d = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        if (we) begin
                            state_d = ST_GET_DATA;
                        end else begin
                            state_d = ST_WB_REQ;
                            cyc_d   = 1'b1;
                            tmr_d   = TMR_LOAD;
                        end
                    end
                end
            end
            ST_GET_DATA: begin
                if (rx_bad) begin
                    state_d = ST_IDLE;
                end else if (rx_good) begin
                    dat_d = {dat[23:0], rx_data};
                    cnt_d = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_d = ST_WB_REQ;
                        cyc_d   = 1'b1;
                        tmr_d   = TMR_LOAD;
                    end
                end
            end
            ST_WB_REQ: begin
                // ack is checked first so it wins over a coincident timeout
                if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = 3'd0;
                    state_d = ST_RESP;
                    if (!we) begin
                        rdata_d = wbm_dat_i;
                    end
                end else if (TMR_EN && tmr == 32'd0) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    idx_d   = 3'd0;
                    state_d = ST_RESP;
                end else if (TMR_EN) begin
                    tmr_d = tmr - 32'd1;
                end
            end
            ST_RESP: begin
                if (txs) begin
                    if (tx_clear) begin
                        txs_d = 1'b0;
                        if (!we && !err && idx != 3'd4) begin
                            idx_d = idx + 3'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (!tx_busy) begin
                    txs_d = 1'b1;
                    txd_d = resp_byte;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_WBM_FRAME_TIMEOUT_EN
        // Reloaded on every received byte; abort only wins when the line is quiet.
        if (state == ST_IDLE) begin
            ftmr_d = FT_LOAD;
        end else if (state == ST_GET_ADDR || state == ST_GET_DATA) begin
            if (rx_valid) begin
                ftmr_d = FT_LOAD;
            end else if (ftmr == 32'd0) begin
                state_d = ST_IDLE;
            end else begin
                ftmr_d = ftmr - 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            we    <= 1'b0;
            cnt   <= 2'd0;
            adr   <= 32'd0;
            dat   <= 32'd0;
            rdata <= 32'd0;
            idx   <= 3'd0;
            err   <= 1'b0;
            txd   <= 8'd0;
            txs   <= 1'b0;
            cyc   <= 1'b0;
            tmr   <= 32'd0;
        end else begin
            state <= state_d;
            we    <= we_d;
            cnt   <= cnt_d;
            adr   <= adr_d;
            dat   <= dat_d;
            rdata <= rdata_d;
            idx   <= idx_d;
            err   <= err_d;
            txd   <= txd_d;
            txs   <= txs_d;
            cyc   <= cyc_d;
            tmr   <= tmr_d;
        end
    end

`ifdef UART_WBM_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftmr <= 32'd0;
        end else begin
            ftmr <= ftmr_d;
        end
    end
`endif

    assign tx_data   = txd;
    assign tx_start  = txs;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = we;
    assign wbm_sel_o = {4{cyc}};
    assign wbm_adr_o = adr;
    assign wbm_dat_o = dat;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// ---------------------------------------------------------------------------
// tb_uart_wb_master
// Scoreboard bench for uart_wb_master. Stimulus pushes the expected bus
// cycles, transmitted bytes and timeout cycle lengths into queues; monitor
// processes pop and compare whenever the DUT presents a bus ack, a latched
// tx byte or the end of a bus cycle. Simple slave and transmitter models
// supply wbm_ack_i/wbm_dat_i and tx_clear/tx_busy.
// ---------------------------------------------------------------------------
module tb_uart_wb_master;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_frame_err = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_clear = 1'b0;
    logic        tx_busy = 1'b0;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    int         exp_len[$];

    logic        ack_en = 1'b1;
    int          ack_delay = 3;
    logic [31:0] rd_data = 32'h0;

    uart_wb_master #(
        .TIMEOUT_CYCLES(16),
        .FRAME_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_clear    (tx_clear),
        .tx_busy     (tx_busy),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wishbone slave: acks ack_delay cycles after cyc/stb rise
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                wbm_ack_i = 1'b0;
                cnt = 0;
            end else if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
                cnt = 0;
            end else if (wbm_cyc_o && wbm_stb_o && ack_en) begin
                if (cnt == ack_delay - 1) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = rd_data;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Transmitter: latches 2 cycles after tx_start, then shifts for a while
    initial begin
        int wc = 0;
        int bc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                tx_clear = 1'b0;
                tx_busy = 1'b0;
                wc = 0;
            end else if (tx_clear) begin
                tx_clear = 1'b0;
                tx_busy = 1'b1;
                bc = 5;
            end else if (tx_busy) begin
                if (bc == 0) tx_busy = 1'b0;
                else bc--;
            end else if (tx_start) begin
                if (wc == 2) begin
                    tx_clear = 1'b1;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
    end

    // Bus monitor
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wbm_cyc_o && wbm_ack_i) begin
                if (exp_bus.size() == 0) begin
                    chk("unexpected_bus_cycle", 32'd1, 32'd0);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_we", {31'd0, wbm_we_o}, {31'd0, e.we});
                    chk("bus_adr", wbm_adr_o, e.adr);
                    chk("bus_sel", {28'd0, wbm_sel_o}, 32'hF);
                    chk("bus_stb", {31'd0, wbm_stb_o}, 32'd1);
                    if (e.we) chk("bus_dat", wbm_dat_o, e.dat);
                end
            end
        end
    end

    // Cycle-length monitor (only checked when a length is expected)
    initial begin
        int len = 0;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o) begin
                len++;
            end else begin
                if (prev && exp_len.size() != 0) chk("cyc_len", len, exp_len.pop_front());
                len = 0;
            end
            prev = wbm_cyc_o;
        end
    end

    // Transmit monitor
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !prev) chk("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
            if (tx_start && tx_clear) begin
                if (exp_tx.size() == 0) chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            prev = tx_start;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic ferr);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_valid = 1'b1;
        rx_frame_err = ferr;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52, 1'b0);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b0);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b0);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b0);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b0);
    endtask

    task automatic wait_done(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_bus.size() == 0 && exp_tx.size() == 0 && exp_len.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
        exp_bus.delete();
        exp_tx.delete();
        exp_len.delete();
    endtask

    initial begin
        bus_t b;
        repeat (3) @(posedge clk);
        #1;
        // reset values
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("rst_we", {31'd0, wbm_we_o}, 32'd0);
        chk("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // write with ack after 3 cycles
        b = '{we: 1'b1, adr: 32'h3800_0010, dat: 32'hDEAD_BEEF};
        exp_bus.push_back(b);
        exp_tx.push_back(8'h4B);
        send_write(32'h3800_0010, 32'hDEAD_BEEF);
        wait_done("write_done");
        chk("write_busy_low", {31'd0, busy}, 32'd0);

        // read of status register
        rd_data = 32'h0000_0015;
        b = '{we: 1'b0, adr: 32'h3840_0000, dat: 32'h0};
        exp_bus.push_back(b);
        exp_tx.push_back(8'h4B); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h15);
        send_read(32'h3840_0000);
        wait_done("read_done");

        // bus timeout: 16 cycles of cyc, then 'E' only
        ack_en = 1'b0;
        exp_len.push_back(16);
        exp_tx.push_back(8'h45);
        send_write(32'h0000_0020, 32'h1122_3344);
        wait_done("timeout_done");
        ack_en = 1'b1;

        // framing: stray byte ignored, then frame aborted by a bad byte
        send_byte(8'h41, 1'b0);
        repeat (2) @(negedge clk);
        chk("stray_byte_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h52, 1'b0);
        send_byte(8'h38, 1'b0);
        send_byte(8'h40, 1'b1);
        repeat (2) @(negedge clk);
        chk("frame_err_idle", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        chk("frame_err_no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        rd_data = 32'hA1B2_C3D4;
        b = '{we: 1'b0, adr: 32'h3800_0004, dat: 32'h0};
        exp_bus.push_back(b);
        exp_tx.push_back(8'h4B); exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2);
        exp_tx.push_back(8'hC3); exp_tx.push_back(8'hD4);
        send_read(32'h3800_0004);
        wait_done("read_after_err_done");

        // asynchronous reset during a bus cycle
        ack_en = 1'b0;
        send_write(32'h3800_0100, 32'h0BAD_F00D);
        for (int i = 0; i < 10 && !wbm_cyc_o; i++) @(negedge clk);
        chk("cyc_before_reset", {31'd0, wbm_cyc_o}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("async_rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_en = 1'b1;
        b = '{we: 1'b1, adr: 32'h3800_0200, dat: 32'hCAFE_0001};
        exp_bus.push_back(b);
        exp_tx.push_back(8'h4B);
        send_write(32'h3800_0200, 32'hCAFE_0001);
        wait_done("write_after_reset_done");

`ifdef UART_WBM_FRAME_TIMEOUT_EN
        send_byte(8'h57, 1'b0);
        send_byte(8'h38, 1'b0);
        repeat (110) @(negedge clk);
        chk("frame_timeout_idle", {31'd0, busy}, 32'd0);
        b = '{we: 1'b1, adr: 32'h3800_0300, dat: 32'h1234_5678};
        exp_bus.push_back(b);
        exp_tx.push_back(8'h4B);
        send_write(32'h3800_0300, 32'h1234_5678);
        wait_done("write_after_frame_timeout_done");
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- UART-to-Wishbone bridge: the initiator counterpart of the existing Wishbone-slave UART/accelerator wrapper.
- Parses a byte-framed command stream from uart_receive and issues single 32-bit Wishbone master cycles (read or write).
- Returns an ack/error byte and any read data through uart_transmission.
- Lets a host PC peek/poke the user address space (bram 0x380x_xxxx, accelerators, status 0x3840_0000) without the CPU.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waiting for wbm_ack_i before error; 0 disables timeout
FRAME_TIMEOUT, 400000, max idle cycles between bytes of one command frame (used only with optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received byte from uart_receive
rx_valid  input  1  one-cycle pulse, rx_data valid
rx_frame_err  input  1  qualifies rx_valid; byte had bad stop bit
tx_data  output  8  byte to transmit
tx_start  output  1  transmit request, level, held until tx_clear
tx_clear  input  1  one-cycle pulse, transmitter latched tx_data
tx_busy  input  1  transmitter shifting
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  1 = write
wbm_sel_o  output  4  byte selects, always 4'hF during a cycle
wbm_adr_o  output  32  address
wbm_dat_o  output  32  write data
wbm_dat_i  input  32  read data
wbm_ack_i  input  1  slave acknowledge
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_data=0, tx_start=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, busy=0. A cycle in flight is dropped immediately; no response is sent.
- Frame format, multi-byte fields MSB first:
  - Write: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52 'R', A3 A2 A1 A0.
- Responses:
  - Write OK: 0x4B 'K'.
  - Read OK: 0x4B, then data bytes MSB first.
  - Timeout: 0x45 'E' only.
- States:
  - IDLE: on rx_valid with a good byte, 0x57/0x52 latches we and goes to GET_ADDR (2-bit byte count cleared). Any other byte is ignored.
  - GET_ADDR: each good byte shifts into wbm_adr_o (adr <= {adr[23:0], byte}). After the 4th byte: write goes to GET_DATA; read goes to WB_REQ.
  - GET_DATA: shifts likewise into wbm_dat_o. After the 4th byte goes to WB_REQ.
  - WB_REQ: cyc=stb=1, sel=F.
    - On wbm_ack_i: drop cyc/stb next cycle; for a read, capture wbm_dat_i into the response register. Then go to RESP, byte 'K'.
    - On timeout count reaching TIMEOUT_CYCLES-1 with no ack: drop cyc/stb; go to RESP, byte 'E'.
  - RESP: drive tx_data and assert tx_start only while tx_busy=0. Hold tx_start and tx_data until tx_clear; deassert tx_start the cycle after tx_clear. Then:
    - Read 'K': sends 4 data bytes the same way, then goes to IDLE.
    - Otherwise goes to IDLE.
- Latency: the last frame byte's rx_valid at cycle N gives cyc/stb high at N+1. An ack sampled at cycle M gives cyc/stb low at M+1 and tx_start high at M+2 if tx_busy=0.
- Ack in the same cycle as timeout expiry: ack wins, response 'K'.
- rx_frame_err=1 with rx_valid:
  - In IDLE: byte ignored.
  - In GET_ADDR/GET_DATA: frame aborted, return to IDLE, no response.
- rx_valid during WB_REQ/RESP: byte discarded. Not queued.
- wbm_adr_o/wbm_dat_o keep their last values in IDLE. Only cyc/stb qualify the bus.

Optional Feature:
- Macro UART_WBM_FRAME_TIMEOUT_EN.
- Defined: a counter runs in GET_ADDR/GET_DATA, resets on each rx_valid, and at FRAME_TIMEOUT-1 cycles aborts the frame to IDLE with no response and no bus cycle.
- Undefined: a partial frame waits indefinitely; the counter logic is absent.

Test Plan:
- Write: bytes 57 38 00 00 10 DE AD BE EF, slave acks after 3 cycles -> one cycle with we=1, adr=0x3800_0010, dat=0xDEADBEEF, sel=F; tx byte 0x4B; busy returns 0.
- Read: bytes 52 38 40 00 00, slave returns 0x0000_0015 -> we=0, adr=0x3840_0000; tx sequence 4B 00 00 00 15, each tx_start held until its tx_clear.
- Timeout: TIMEOUT_CYCLES=16, write frame, no ack -> cyc/stb high exactly 16 cycles then low; tx 0x45 only.
- Framing: idle byte 0x41 ignored; then 52 38 with rx_frame_err on the 3rd byte -> no bus cycle, no tx, state IDLE. A following valid read frame completes normally.
- Reset mid-cycle: rst_n low while cyc=1 -> cyc/stb/tx_start 0 the same cycle (async). After release, a new frame works.
- With UART_WBM_FRAME_TIMEOUT_EN, FRAME_TIMEOUT=100: send 57 38 then silence 100 cycles -> back to IDLE, no cycle; next full frame accepted.
